// File: rtl/osd_ctm_callfilter_if.sv
// Output event bus of the call filter: valid/ready handshake plus captured event fields.
interface osd_ctm_callfilter_if #(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned DEPTH_WIDTH = 8
);
    logic                   out_valid;
    logic                   out_ready;
    logic [ADDR_WIDTH-1:0]  out_pc;
    logic [ADDR_WIDTH-1:0]  out_npc;
    logic                   out_call;
    logic                   out_ret;
    logic                   out_prvchg;
    logic [1:0]             out_prv;
    logic [DEPTH_WIDTH-1:0] out_depth;
    logic [7:0]             out_dropped;

    modport master (
        output out_valid, out_pc, out_npc, out_call, out_ret, out_prvchg, out_prv,
               out_depth, out_dropped,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_pc, out_npc, out_call, out_ret, out_prvchg, out_prv,
               out_depth, out_dropped,
        output out_ready
    );
endinterface

// File: rtl/osd_ctm_callfilter.sv
// Call/return/privilege-change pre-filter with a 2-entry output queue and drop counting.
// Define OSD_CTM_CALLFILTER_DEPTH_EN to include the call-depth counter and depth window filter.
module osd_ctm_callfilter #(
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned DEPTH_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   trace_valid,
    input  logic [ADDR_WIDTH-1:0]  trace_pc,
    input  logic [ADDR_WIDTH-1:0]  trace_npc,
    input  logic                   trace_jal,
    input  logic                   trace_jalr,
    input  logic                   trace_mem,
    input  logic [1:0]             trace_prv,
    input  logic                   cfg_enable,
    input  logic [DEPTH_WIDTH-1:0] cfg_max_depth,
    osd_ctm_callfilter_if.master   out_if
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [ADDR_WIDTH-1:0]  npc;
        logic                   call;
        logic                   ret;
        logic                   prvchg;
        logic [1:0]             prv;
        logic [DEPTH_WIDTH-1:0] depth;
        logic [7:0]             dropped;
    } entry_t;

    // fifo_q[0] is always the head presented on the output bus
    entry_t     fifo_q [2];
    entry_t     fifo_d [2];
    logic [1:0] count_q, count_d;
    logic [7:0] drop_q, drop_d;
    logic [1:0] prv_q;

    logic                   qual;
    logic                   is_call;
    logic                   is_ret;
    logic                   prvchg;
    logic                   is_event;
    logic                   eligible;
    logic                   pop;
    logic                   room;
    logic                   push;
    logic [1:0]             wr_idx;
    logic [DEPTH_WIDTH-1:0] ev_depth;
    logic                   in_window;
    entry_t                 new_entry;

    assign qual     = trace_valid & ~trace_mem;
    assign is_call  = qual & trace_jal;
    assign is_ret   = qual & trace_jalr;
    assign prvchg   = (prv_q != trace_prv);
    assign is_event = is_call | is_ret | prvchg;

`ifdef OSD_CTM_CALLFILTER_DEPTH_EN
    logic [DEPTH_WIDTH-1:0] depth_q, depth_d;

    // Calls report the depth they were made from, returns the depth they land at
    always_comb begin
        depth_d  = depth_q;
        ev_depth = depth_q;
        if (is_call) begin
            if (depth_q != '1) depth_d = depth_q + 1'b1;
        end else if (is_ret) begin
            if (depth_q != '0) depth_d = depth_q - 1'b1;
            ev_depth = depth_d;
        end
        in_window = (ev_depth <= cfg_max_depth);
    end

    always_ff @(posedge clk) begin
        if (rst) depth_q <= '0;
        else     depth_q <= depth_d;
    end
`else
    logic unused_max_depth;

    assign unused_max_depth = ^cfg_max_depth;
    assign ev_depth         = '0;
    assign in_window        = 1'b1;
`endif

    assign pop      = out_if.out_valid & out_if.out_ready;
    assign room     = (count_q != 2'd2) | pop;
    assign eligible = cfg_enable & is_event & (prvchg | in_window);
    assign push     = eligible & room;
    assign wr_idx   = count_q - {1'b0, pop};

    always_comb begin
        new_entry.pc      = trace_pc;
        new_entry.npc     = trace_npc;
        new_entry.call    = is_call;
        new_entry.ret     = is_ret;
        new_entry.prvchg  = prvchg;
        new_entry.prv     = trace_prv;
        new_entry.depth   = ev_depth;
        new_entry.dropped = drop_q;
    end

    always_comb begin
        fifo_d[0] = fifo_q[0];
        fifo_d[1] = fifo_q[1];
        count_d   = count_q;
        drop_d    = drop_q;

        if (pop) fifo_d[0] = fifo_q[1];
        if (push) fifo_d[wr_idx[0]] = new_entry;
        count_d = count_q + {1'b0, push} - {1'b0, pop};

        // Filtered events never reach here; only eligible events that found no room count
        if (push) begin
            drop_d = '0;
        end else if (eligible && drop_q != 8'hff) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            count_q   <= '0;
            drop_q    <= '0;
            prv_q     <= 2'b11;
        end else begin
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            count_q   <= count_d;
            drop_q    <= drop_d;
            prv_q     <= trace_prv;
        end
    end

    assign out_if.out_valid   = (count_q != 2'd0);
    assign out_if.out_pc      = fifo_q[0].pc;
    assign out_if.out_npc     = fifo_q[0].npc;
    assign out_if.out_call    = fifo_q[0].call;
    assign out_if.out_ret     = fifo_q[0].ret;
    assign out_if.out_prvchg  = fifo_q[0].prvchg;
    assign out_if.out_prv     = fifo_q[0].prv;
    assign out_if.out_depth   = fifo_q[0].depth;
    assign out_if.out_dropped = fifo_q[0].dropped;

endmodule

// File: tb/tb_osd_ctm_callfilter.sv
// Self-checking bench for osd_ctm_callfilter: directed scenarios plus random traffic vs. a queue model.
module tb_osd_ctm_callfilter;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 8;
`ifdef OSD_CTM_CALLFILTER_DEPTH_EN
    localparam bit DepthEn = 1'b1;
`else
    localparam bit DepthEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          trace_valid, trace_jal, trace_jalr, trace_mem;
    logic [AW-1:0] trace_pc, trace_npc;
    logic [1:0]    trace_prv;
    logic          cfg_enable;
    logic [DW-1:0] cfg_max_depth;
    logic          ready;

    always #5 clk = ~clk;

    osd_ctm_callfilter_if #(.ADDR_WIDTH(AW), .DEPTH_WIDTH(DW)) bus ();
    assign bus.out_ready = ready;

    osd_ctm_callfilter #(.ADDR_WIDTH(AW), .DEPTH_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .trace_valid   (trace_valid),
        .trace_pc      (trace_pc),
        .trace_npc     (trace_npc),
        .trace_jal     (trace_jal),
        .trace_jalr    (trace_jalr),
        .trace_mem     (trace_mem),
        .trace_prv     (trace_prv),
        .cfg_enable    (cfg_enable),
        .cfg_max_depth (cfg_max_depth),
        .out_if        (bus)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic [AW-1:0] npc;
        bit            call;
        bit            ret;
        bit            prvchg;
        int            prv;
        int            depth;
        int            dropped;
    } ev_t;

    ev_t q[$];
    int  m_depth, m_drop, m_prv;
    int  n_checks = 0;
    int  n_err    = 0;
    int  pops     = 0;
    bit  found;

    function automatic logic [255:0] ev_vec(ev_t e);
        logic [1:0] p;
        logic [7:0] d, x;
        p = e.prv[1:0];
        d = e.depth[7:0];
        x = e.dropped[7:0];
        return {107'b0, e.pc, e.npc, e.call, e.ret, e.prvchg, p, d, x};
    endfunction

    function automatic logic [255:0] dut_vec();
        return {107'b0, bus.out_pc, bus.out_npc, bus.out_call, bus.out_ret, bus.out_prvchg,
                bus.out_prv, bus.out_depth, bus.out_dropped};
    endfunction

    task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference behaviour for one clock edge, from the current inputs
    task automatic model();
        bit pop, qual, call, ret, prvchg, ev, elig, room;
        int evd;
        ev_t e;
        if (rst) begin
            q.delete();
            m_depth = 0;
            m_drop  = 0;
            m_prv   = 3;
            return;
        end
        pop    = (q.size() > 0) && ready;
        qual   = trace_valid && !trace_mem;
        call   = qual && trace_jal;
        ret    = qual && trace_jalr;
        prvchg = (int'(trace_prv) != m_prv);
        evd    = 0;
        if (DepthEn) begin
            if (call) begin
                evd     = m_depth;
                m_depth = (m_depth < 255) ? m_depth + 1 : 255;
            end else if (ret) begin
                m_depth = (m_depth > 0) ? m_depth - 1 : 0;
                evd     = m_depth;
            end else begin
                evd = m_depth;
            end
        end
        ev   = call || ret || prvchg;
        elig = ev && cfg_enable && (prvchg || !DepthEn || evd <= int'(cfg_max_depth));
        room = (q.size() < 2) || pop;
        if (pop) void'(q.pop_front());
        if (elig && room) begin
            e.pc = trace_pc;  e.npc = trace_npc;
            e.call = call;    e.ret = ret;     e.prvchg = prvchg;
            e.prv = int'(trace_prv); e.depth = evd; e.dropped = m_drop;
            q.push_back(e);
            m_drop = 0;
        end else if (elig) begin
            m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
        m_prv = int'(trace_prv);
    endtask

    task automatic step();
        if (bus.out_valid && ready) pops++;
        model();
        @(posedge clk);
        #1;
        check("valid", bus.out_valid, q.size() != 0);
        if (q.size() != 0) check("head", dut_vec(), ev_vec(q[0]));
    endtask

    task automatic idle();
        trace_valid = 1'b0; trace_jal = 1'b0; trace_jalr = 1'b0; trace_mem = 1'b0;
    endtask

    task automatic jal(logic [AW-1:0] pc);
        trace_valid = 1'b1; trace_jal = 1'b1; trace_jalr = 1'b0; trace_mem = 1'b0;
        trace_pc = pc; trace_npc = pc + 64'h1000;
    endtask

    task automatic jalr(logic [AW-1:0] pc);
        trace_valid = 1'b1; trace_jal = 1'b0; trace_jalr = 1'b1; trace_mem = 1'b0;
        trace_pc = pc; trace_npc = pc - 64'h10;
    endtask

    task automatic do_reset();
        idle();
        trace_prv = 2'b11;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic find_pc(logic [AW-1:0] pc);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (bus.out_valid && bus.out_pc == pc) found = 1'b1;
            else step();
        end
    endtask

    initial begin
        rst = 1'b1; ready = 1'b1; cfg_enable = 1'b1; cfg_max_depth = 8'd255;
        trace_pc = '0; trace_npc = '0; trace_prv = 2'b11;
        idle();

        // Reset state and first-event latency
        do_reset();
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_outs", dut_vec(), 256'd0);
        step();
        jal(64'h1000);
        trace_npc = 64'h2000;
        step();
        idle();
        check("t1_valid", bus.out_valid, 1'b1);
        check("t1_call", bus.out_call, 1'b1);
        check("t1_pc", bus.out_pc, 64'h1000);
        check("t1_npc", bus.out_npc, 64'h2000);
        check("t1_depth", bus.out_depth, 8'd0);
        check("t1_dropped", bus.out_dropped, 8'd0);

        // Depth window of 1
        do_reset();
        cfg_max_depth = 8'd1;
        pops = 0;
        for (int i = 0; i < 3; i++) begin jal(64'h100 + 64'(i)); step(); end
        for (int i = 0; i < 3; i++) begin jalr(64'h200 + 64'(i)); step(); end
        idle();
        for (int i = 0; i < 4; i++) step();
        check("win_pops", pops, DepthEn ? 4 : 6);
        jal(64'h300);
        step();
        idle();
        check("win_depth_end", bus.out_depth, 8'd0);

        // Backpressure and drop reporting
        do_reset();
        cfg_max_depth = 8'd255;
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin jal(64'h100 + 64'(4 * i)); step(); end
        idle();
        step();
        check("bp_head_stable", bus.out_pc, 64'h100);
        ready = 1'b1;
        step();
        jal(64'h200);
        step();
        idle();
        find_pc(64'h200);
        check("bp_found", found, 1'b1);
        check("bp_dropped", bus.out_dropped, 8'd3);

        // Privilege change without a retirement
        do_reset();
        for (int i = 0; i < 4; i++) begin jal(64'h500 + 64'(i)); step(); end
        idle();
        step();
        step();
        cfg_max_depth = 8'd0;
        trace_prv = 2'b00;
        step();
        check("prv_chg", bus.out_prvchg, 1'b1);
        check("prv_val", bus.out_prv, 2'b00);
        check("prv_call", bus.out_call, 1'b0);
        check("prv_depth", bus.out_depth, DepthEn ? 8'd4 : 8'd0);

        // Depth underflow and drop counter saturation
        do_reset();
        cfg_max_depth = 8'd0;
        for (int i = 0; i < 300; i++) begin jalr(64'h700); step(); end
        idle();
        step();
        jal(64'h800);
        step();
        idle();
        check("sat_call", bus.out_call, 1'b1);
        check("sat_depth0", bus.out_depth, 8'd0);
        step();
        cfg_max_depth = 8'd255;
        ready = 1'b0;
        for (int i = 0; i < 302; i++) begin jal(64'h900 + 64'(i)); step(); end
        ready = 1'b1;
        idle();
        step();
        jal(64'hA00);
        step();
        idle();
        find_pc(64'hA00);
        check("sat_found", found, 1'b1);
        check("sat_dropped", bus.out_dropped, 8'd255);

        // Push into a full queue while it pops
        do_reset();
        ready = 1'b0;
        jal(64'hB00); step();
        jal(64'hB04); step();
        ready = 1'b1;
        jal(64'hB08); step();
        ready = 1'b0;
        idle();
        step();
        check("fp_head", bus.out_pc, 64'hB04);
        ready = 1'b1;
        step();
        check("fp_next", bus.out_pc, 64'hB08);
        check("fp_dropped", bus.out_dropped, 8'd0);
        step();

        // Random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 499) == 0);
            trace_valid   = $urandom_range(0, 3) != 0;
            trace_jal     = $urandom_range(0, 2) == 0;
            trace_jalr    = $urandom_range(0, 2) == 0;
            trace_mem     = $urandom_range(0, 5) == 0;
            trace_pc      = {$urandom, $urandom};
            trace_npc     = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) trace_prv = 2'($urandom_range(0, 3));
            cfg_enable    = $urandom_range(0, 7) != 0;
            cfg_max_depth = 8'($urandom_range(0, 6));
            ready         = $urandom_range(0, 2) != 0;
            step();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/osd_ctm_callfilter.md
# osd_ctm_callfilter

Pre-filter between the core trace port and the core trace module. Tracks call depth from jump events and keeps only calls, returns and privilege changes inside a configurable depth window. Queues the surviving events in a 2-entry buffer behind a valid/ready handshake. Drops are counted and reported with the next event that is accepted.

## Interface

Parameters:
- ADDR_WIDTH, 64, width of pc/npc
- DEPTH_WIDTH, 8, call-depth counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- trace_valid  in  1  retired-instruction strobe
- trace_pc  in  ADDR_WIDTH  pc of retired instruction
- trace_npc  in  ADDR_WIDTH  next pc
- trace_jal  in  1  instruction is jal (treated as call)
- trace_jalr  in  1  instruction is jalr (treated as return)
- trace_mem  in  1  memory op; a retirement with this set is ignored
- trace_prv  in  2  current privilege level
- cfg_enable  in  1  0: push nothing (depth still tracked)
- cfg_max_depth  in  DEPTH_WIDTH  highest event depth that passes
- out_valid  out  1  event available
- out_ready  in  1  consumer accepts
- out_pc, out_npc  out  ADDR_WIDTH  captured pc/npc
- out_call, out_ret, out_prvchg  out  1 each  event flags
- out_prv  out  2  privilege at capture
- out_depth  out  DEPTH_WIDTH  event depth
- out_dropped  out  8  events lost before this one, saturating at 255

## Operation

- Retirement qualifies when trace_valid & !trace_mem.
- call = qualifying & trace_jal; ret = qualifying & trace_jalr.
- prvchg = (prv_reg != trace_prv), independent of trace_valid.
- prv_reg updates every cycle; reset value 2'b11.
- Depth counter, reset 0:
  - +1 on call, saturating at all-ones.
  - -1 on ret, saturating at 0.
  - call and ret in the same cycle: call takes priority.
- Event depth:
  - call: the value before increment.
  - ret: the value after decrement.
  - prvchg only: the current value.
- An event is formed when call | ret | prvchg.
- The event is pushed only when all of these hold:
  - cfg_enable is 1.
  - prvchg is set, or the event depth ≤ cfg_max_depth.
  - The buffer has room.
- A filtered event (depth window, or cfg_enable=0) is not counted as dropped.
- Buffer: 2-entry FIFO.
  - Push is allowed when count<2, or when count==2 and a pop happens in the same cycle.
  - Simultaneous push and pop at count 1 keeps count 1.
- Drop counter (8-bit, saturating, reset 0):
  - Increments when an eligible event finds no room.
  - On a successful push its value is stored in that entry's out_dropped, and the counter clears to 0 in the same cycle.
- The depth counter updates on every call/ret, whether the event is pushed, filtered or dropped.

## Timing

- Latency: trace inputs at cycle N → out_valid=1 at cycle N+1 with an empty buffer.
- Outputs come from buffer registers; there is no combinational path from trace_* to out_*.
- out_* are stable while out_valid & !out_ready.
- Pop happens on out_valid & out_ready.
- Reset values:
  - out_valid=0, count=0, depth=0, drop counter=0.
  - out_pc, out_npc, out_call, out_ret, out_prvchg, out_prv, out_depth, out_dropped are all 0.
  - prv_reg=2'b11.
- Reset mid-operation: buffered events are discarded, the drop count is lost, and out_valid=0 on the cycle after rst is sampled high.
- cfg_enable and cfg_max_depth are sampled each cycle; a change takes effect on the next event.
- Throughput: 1 event/cycle while out_ready is held high.

## Configuration

- OSD_CTM_CALLFILTER_DEPTH_EN defined:
  - Depth counter and window filter are present as described.
- Not defined:
  - No depth counter; cfg_max_depth is ignored.
  - out_depth is tied to 0.
  - Every call/ret/prvchg is eligible when cfg_enable=1.
  - Buffer, drop counting and handshake are unchanged.

## Test plan

- Reset with rst high 2 cycles → out_valid=0 and all out_* 0. One cycle after release, a jal at pc=0x1000, npc=0x2000 → out_valid=1, out_call=1, out_depth=0, out_dropped=0.
- Window filter with cfg_max_depth=1: jal, jal, jal, jalr, jalr, jalr on consecutive cycles → events emitted with depths 0,1,(filtered 2),(filtered 2),1,0. Exactly 4 pops; depth ends at 0.
- Backpressure: out_ready=0 and 5 consecutive jal with cfg_max_depth=255 → 2 buffered, count stays 2. Release out_ready, then one more jal → that event carries out_dropped=3.
- Privilege change: trace_prv 3→0 with trace_valid=0 and cfg_max_depth=0 at depth 4 → event with out_prvchg=1, out_prv=0, out_call=0, out_depth=4.
- Saturation: 300 consecutive jalr from depth 0 → depth stays 0. 300 overflowing eligible events with out_ready=0 → next accepted event has out_dropped=255.
- Full with simultaneous pop: count=2, out_ready=1, new jal in the same cycle → push accepted, count stays 2, out_dropped=0.
